// File: rtl/dm_if.sv
// dm_if: M-stage data port plus store-trace stream of dm_responder.
// bound_err exists only when DM_BOUNDS_CHECK_EN is defined.
interface dm_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  trace_byteen;
  logic        trace_overflow;
  logic [31:0] write_count;
`ifdef DM_BOUNDS_CHECK_EN
  logic        bound_err;
  modport master (output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
                  input m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data, trace_byteen,
                  trace_overflow, write_count, bound_err);
  modport slave (input m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
                 output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data, trace_byteen,
                 trace_overflow, write_count, bound_err);
`else
  modport master (output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
                  input m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data, trace_byteen,
                  trace_overflow, write_count);
  modport slave (input m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
                 output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data, trace_byteen,
                 trace_overflow, write_count);
`endif
endinterface

// File: rtl/dm_responder.sv
// dm_responder: byte-enabled data memory with combinational reads and a store-trace FIFO.
// DM_BOUNDS_CHECK_EN: out-of-range stores are logged with byteen 0 and raise bound_err.
module dm_responder #(
  parameter int ADDR_W      = 12,
  parameter int TRACE_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);
  localparam int PW = $clog2(TRACE_DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } trace_t;
  logic [31:0]       r_mem [2**ADDR_W];
  trace_t            r_fifo [TRACE_DEPTH];
  logic [PW:0]       r_wp, r_rp;
  logic              r_overflow;
  logic [31:0]       r_wcnt;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_old, w_merged;
  logic              w_oob, w_push, w_commit, w_pop, w_empty, w_full, w_unused;
  trace_t            w_head;
  assign w_idx = bus.m_data_addr[ADDR_W+1:2];
  assign w_old = r_mem[w_idx];
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign w_merged[8*l+:8] = bus.m_data_byteen[l] ? bus.m_data_wdata[8*l+:8] : w_old[8*l+:8];
  end
`ifdef DM_BOUNDS_CHECK_EN
  logic r_bound_err;
  assign w_oob = |bus.m_data_addr[31:ADDR_W+2];
  assign bus.bound_err = r_bound_err;
  always_ff @(posedge clk)
    if (reset) r_bound_err <= 1'b0;
    else if (w_oob) r_bound_err <= 1'b1;
`else
  assign w_oob = 1'b0;
`endif
  assign w_unused = ^{bus.m_data_addr[1:0], bus.m_data_addr[31:ADDR_W+2]};
  assign w_push   = |bus.m_data_byteen;
  assign w_commit = w_push & ~w_oob;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_pop    = ~w_empty & bus.trace_ready;
  assign w_head   = r_fifo[r_rp[PW-1:0]];
  assign bus.m_data_rdata   = w_oob ? 32'h0 : w_old;
  assign bus.trace_valid    = ~w_empty;
  assign bus.trace_pc       = w_empty ? 32'h0 : w_head.pc;
  assign bus.trace_addr     = w_empty ? 32'h0 : w_head.addr;
  assign bus.trace_data     = w_empty ? 32'h0 : w_head.data;
  assign bus.trace_byteen   = w_empty ? 4'h0 : w_head.be;
  assign bus.trace_overflow = r_overflow;
  assign bus.write_count    = r_wcnt;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_overflow <= 1'b0;
      r_wcnt     <= '0;
    end else begin
      if (w_commit) begin
        r_mem[w_idx] <= w_merged;
        r_wcnt       <= r_wcnt + 32'd1;
      end
      if (w_push && (!w_full || w_pop)) begin
        r_fifo[r_wp[PW-1:0]] <= '{bus.m_inst_addr, {bus.m_data_addr[31:2], 2'b00}, w_merged,
                                  w_oob ? 4'h0 : bus.m_data_byteen};
        r_wp <= r_wp + 1'b1;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
endmodule
